// File: rtl/fc_layer_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fc_layer_param                                                |
// | Brief    : Fully-connected layer y = act(W.x) with P parallel MAC lanes,  |
// |            run-time weight stream and valid/ready x / y streams.         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fc_layer_param #(
    parameter int M     = 8,
    parameter int N     = 8,
    parameter int P     = 2,
    parameter int WIDTH = 16,
    parameter int RELU  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] s_data_in_w,
    input  logic             s_valid_w,
    output logic             s_ready_w,
    input  logic [WIDTH-1:0] s_data_in_x,
    input  logic             s_valid_x,
    output logic             s_ready_x,
    output logic [WIDTH-1:0] m_data_out_y,
    output logic             m_valid_y,
    input  logic             m_ready_y
);

    localparam int c_RW     = (M > 1) ? $clog2(M) : 1;
    localparam int c_CW     = (N > 1) ? $clog2(N) : 1;
    localparam int c_JW     = $clog2(N + 1);
    localparam int c_GW     = ((M / P) > 1) ? $clog2(M / P) : 1;
    localparam int c_PW     = (P > 1) ? $clog2(P) : 1;
    localparam int c_PROD_W = 2 * WIDTH;
    localparam int c_ACC_W  = 2 * WIDTH + $clog2(N);

    localparam logic signed [c_ACC_W-1:0] c_MAX =
        {{(c_ACC_W - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [c_ACC_W-1:0] c_MIN =
        {{(c_ACC_W - WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

    localparam logic [1:0] c_ST_LOAD_W  = 2'd0;
    localparam logic [1:0] c_ST_LOAD_X  = 2'd1;
    localparam logic [1:0] c_ST_COMPUTE = 2'd2;
    localparam logic [1:0] c_ST_OUTPUT  = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [c_RW-1:0]   r_wrow;
    logic [c_CW-1:0]   r_wcol;
    logic [c_CW-1:0]   r_xi;
    logic [c_JW-1:0]   r_cnt;
    logic [c_GW-1:0]   r_grp;
    logic [c_PW-1:0]   r_oi;

    logic [WIDTH-1:0]            r_wmem [M][N];
    logic [WIDTH-1:0]            r_xmem [N];
    logic [WIDTH-1:0]            r_x_rd;
    logic [WIDTH-1:0]            r_w_rd [P];
    logic signed [c_ACC_W-1:0]   r_acc  [P];
    logic signed [c_PROD_W-1:0]  w_prod [P];
    logic [c_RW-1:0]             w_rd_row [P];
    logic [c_CW-1:0]             w_rd_col;

    logic w_w_fire;
    logic w_x_fire;
    logic w_y_fire;
    logic w_w_last;
    logic w_x_last;
    logic w_mac_done;
    logic w_o_last;
    logic w_g_last;

    function automatic logic [WIDTH-1:0] f_act_sat(input logic signed [c_ACC_W-1:0] acc);
        logic [WIDTH-1:0] res;
        res = acc[WIDTH-1:0];
        if ((RELU != 0) && acc[c_ACC_W-1]) begin
            res = '0;
        end else if (acc > c_MAX) begin
            res = c_MAX[WIDTH-1:0];
        end else if (acc < c_MIN) begin
            res = c_MIN[WIDTH-1:0];
        end
        return res;
    endfunction

    // Handshake outputs are masked while reset is held so they read 0 immediately.
    assign s_ready_w    = reset && (r_state == c_ST_LOAD_W);
    assign s_ready_x    = reset && (r_state == c_ST_LOAD_X);
    assign m_valid_y    = reset && (r_state == c_ST_OUTPUT);
    assign m_data_out_y = m_valid_y ? f_act_sat(r_acc[r_oi]) : '0;

    assign w_w_fire   = s_valid_w && s_ready_w;
    assign w_x_fire   = s_valid_x && s_ready_x;
    assign w_y_fire   = m_valid_y && m_ready_y;
    assign w_w_last   = (r_wrow == c_RW'(M - 1)) && (r_wcol == c_CW'(N - 1));
    assign w_x_last   = (r_xi == c_CW'(N - 1));
    assign w_mac_done = (r_cnt == c_JW'(N));
    assign w_o_last   = (r_oi == c_PW'(P - 1));
    assign w_g_last   = (r_grp == c_GW'((M / P) - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_ST_LOAD_W;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_LOAD_W:  if (w_w_fire && w_w_last) w_state_nxt = c_ST_LOAD_X;
            c_ST_LOAD_X:  if (w_x_fire && w_x_last) w_state_nxt = c_ST_COMPUTE;
            c_ST_COMPUTE: if (w_mac_done)           w_state_nxt = c_ST_OUTPUT;
            c_ST_OUTPUT: begin
                if (w_y_fire && w_o_last) begin
                    w_state_nxt = w_g_last ? c_ST_LOAD_X : c_ST_COMPUTE;
                end
            end
            default:      w_state_nxt = c_ST_LOAD_W;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wrow <= '0;
            r_wcol <= '0;
            r_xi   <= '0;
            r_cnt  <= '0;
            r_grp  <= '0;
            r_oi   <= '0;
        end else begin
            if (w_w_fire) begin
                if (r_wcol == c_CW'(N - 1)) begin
                    r_wcol <= '0;
                    r_wrow <= r_wrow + 1'b1;
                end else begin
                    r_wcol <= r_wcol + 1'b1;
                end
            end
            if (w_x_fire) begin
                r_xi <= w_x_last ? '0 : r_xi + 1'b1;
            end
            if (r_state == c_ST_COMPUTE) begin
                r_cnt <= w_mac_done ? '0 : r_cnt + 1'b1;
            end
            if (w_y_fire) begin
                r_oi <= w_o_last ? '0 : r_oi + 1'b1;
                if (w_o_last) begin
                    r_grp <= w_g_last ? '0 : r_grp + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_w_fire) begin
            r_wmem[r_wrow][r_wcol] <= s_data_in_w;
        end
        if (w_x_fire) begin
            r_xmem[r_xi] <= s_data_in_x;
        end
    end

    assign w_rd_col = r_cnt[c_CW-1:0];

    genvar k;
    generate
        for (k = 0; k < P; k++) begin : g_lane
            assign w_rd_row[k] = c_RW'(int'(r_grp) * P + k);
            assign w_prod[k]   = c_PROD_W'($signed(r_w_rd[k])) * c_PROD_W'($signed(r_x_rd));
        end
    endgenerate

    // Cycle 0 of COMPUTE only issues the first read and clears the sums;
    // cycles 1..N each add the product of the operands read one cycle earlier.
    always_ff @(posedge clk) begin
        if (r_state == c_ST_COMPUTE) begin
            r_x_rd <= r_xmem[w_rd_col];
            for (int l = 0; l < P; l++) begin
                r_w_rd[l] <= r_wmem[w_rd_row[l]][w_rd_col];
                if (r_cnt == '0) begin
                    r_acc[l] <= '0;
                end else begin
                    r_acc[l] <= r_acc[l] + c_ACC_W'(w_prod[l]);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fc_layer_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fc_layer_param                                             |
// | Brief    : Self-checking bench; RELU=1 and RELU=0 instances share inputs. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_fc_layer_param;

    localparam int M      = 4;
    localparam int N      = 3;
    localparam int P      = 2;
    localparam int WIDTH  = 16;
    localparam int c_MAXV = (1 << (WIDTH - 1)) - 1;
    localparam int c_MINV = -(1 << (WIDTH - 1));

    typedef struct {
        int w  [M*N];
        int x  [N];
        int y1 [M];
        int y0 [M];
        int gap;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] s_data_in_w;
    logic             s_valid_w;
    logic [WIDTH-1:0] s_data_in_x;
    logic             s_valid_x;
    logic             m_ready_y;

    logic             w_ready_w_r, w_ready_x_r, w_valid_y_r;
    logic [WIDTH-1:0] w_data_y_r;
    logic             w_ready_w_l, w_ready_x_l, w_valid_y_l;
    logic [WIDTH-1:0] w_data_y_l;

    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   t_xlast = 0;
    int   wm [M][N];
    int   xv [N];
    vec_t tbl [4];

    fc_layer_param #(.M(M), .N(N), .P(P), .WIDTH(WIDTH), .RELU(1)) u_dut_relu (
        .clk          (clk),
        .reset        (reset),
        .s_data_in_w  (s_data_in_w),
        .s_valid_w    (s_valid_w),
        .s_ready_w    (w_ready_w_r),
        .s_data_in_x  (s_data_in_x),
        .s_valid_x    (s_valid_x),
        .s_ready_x    (w_ready_x_r),
        .m_data_out_y (w_data_y_r),
        .m_valid_y    (w_valid_y_r),
        .m_ready_y    (m_ready_y)
    );

    fc_layer_param #(.M(M), .N(N), .P(P), .WIDTH(WIDTH), .RELU(0)) u_dut_lin (
        .clk          (clk),
        .reset        (reset),
        .s_data_in_w  (s_data_in_w),
        .s_valid_w    (s_valid_w),
        .s_ready_w    (w_ready_w_l),
        .s_data_in_x  (s_data_in_x),
        .s_valid_x    (s_valid_x),
        .s_ready_x    (w_ready_x_l),
        .m_data_out_y (w_data_y_l),
        .m_valid_y    (w_valid_y_l),
        .m_ready_y    (m_ready_y)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain signed dot product, optional clamp at 0, then saturation.
    function automatic int ref_y(input int i, input bit relu);
        longint acc;
        acc = 0;
        for (int j = 0; j < N; j++) acc += longint'(wm[i][j]) * longint'(xv[j]);
        if (relu && acc < 0) acc = 0;
        if (acc > c_MAXV) acc = c_MAXV;
        if (acc < c_MINV) acc = c_MINV;
        return int'(acc);
    endfunction

    function automatic int rnd_val();
        logic signed [WIDTH-1:0] v;
        if ($urandom_range(9) < 2) v = WIDTH'($urandom);
        else                       v = WIDTH'($urandom_range(400)) - WIDTH'(200);
        return int'(v);
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_ready_w_r"}, w_ready_w_r, 0);
        chk({tag, "_ready_x_r"}, w_ready_x_r, 0);
        chk({tag, "_valid_y_r"}, w_valid_y_r, 0);
        chk({tag, "_data_y_r"},  w_data_y_r,  0);
        chk({tag, "_ready_w_l"}, w_ready_w_l, 0);
        chk({tag, "_ready_x_l"}, w_ready_x_l, 0);
        chk({tag, "_valid_y_l"}, w_valid_y_l, 0);
        chk({tag, "_data_y_l"},  w_data_y_l,  0);
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        s_valid_w = 1'b0;
        s_valid_x = 1'b0;
        m_ready_y = 1'b0;
        #1;
        chk_idle("rst");
        tick();
        chk_idle("rst_held");
        reset = 1'b1;
        #1;
        chk("ready_w_after_rst", w_ready_w_r, 1);
        chk("ready_x_after_rst", w_ready_x_r, 0);
    endtask

    task automatic set_basic_w();
        int b [M*N];
        b = '{1, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 1};
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) wm[i][j] = b[i*N + j];
    endtask

    task automatic load_w(input int gap);
        int k = 0;
        int guard = 0;
        bit fired;
        while (k < M*N && guard < 500) begin
            guard++;
            if ($urandom_range(99) < gap) begin
                s_valid_w   = 1'b0;
                s_data_in_w = WIDTH'($urandom);
            end else begin
                s_valid_w   = 1'b1;
                s_data_in_w = WIDTH'(wm[k / N][k % N]);
            end
            fired = s_valid_w && w_ready_w_r;
            tick();
            if (fired) k++;
        end
        s_valid_w = 1'b0;
        if (k < M*N) chk("w_load_timeout", k, M*N);
        chk("ready_x_after_w", w_ready_x_r, 1);
    endtask

    // Weight stream is driven with junk throughout; it must be ignored.
    task automatic load_x(input int gap);
        int k = 0;
        int guard = 0;
        bit fired;
        while (k < N && guard < 400) begin
            guard++;
            s_valid_w   = 1'b1;
            s_data_in_w = WIDTH'($urandom);
            if ($urandom_range(99) < gap) begin
                s_valid_x   = 1'b0;
                s_data_in_x = WIDTH'($urandom);
            end else begin
                s_valid_x   = 1'b1;
                s_data_in_x = WIDTH'(xv[k]);
            end
            fired = s_valid_x && w_ready_x_r;
            if (fired && k == N - 1) t_xlast = cyc;
            tick();
            if (fired) k++;
        end
        s_valid_x = 1'b0;
        s_valid_w = 1'b0;
        if (k < N) chk("x_load_timeout", k, N);
    endtask

    // mode 0: ready held high, 1: random ready, 2: ready low 5 cycles before each output
    task automatic recv_y(input int mode, input int e1 [M], input int e0 [M]);
        int idx = 0;
        int guard = 0;
        int hold = 0;
        int t_prev;
        int stab_bad = 0;
        int rdy_bad = 0;
        bit seen = 1'b0;
        bit prev_stall = 1'b0;
        bit fire;
        logic [WIDTH-1:0] prev_r = '0;
        logic [WIDTH-1:0] prev_l = '0;
        t_prev = t_xlast;
        while (idx < M && guard < 400) begin
            guard++;
            s_valid_w   = 1'b1;
            s_data_in_w = WIDTH'($urandom);
            s_valid_x   = 1'b1;
            s_data_in_x = WIDTH'($urandom);
            if (prev_stall && (!w_valid_y_r || w_data_y_r !== prev_r || w_data_y_l !== prev_l))
                stab_bad++;
            if (w_ready_x_r || w_ready_w_r) rdy_bad++;
            if (w_valid_y_r && !seen) begin
                seen = 1'b1;
                chk($sformatf("y_latency_grp%0d", idx / P), cyc - t_prev, N + 2);
            end
            case (mode)
                0:       m_ready_y = 1'b1;
                1:       m_ready_y = 1'($urandom_range(1));
                default: m_ready_y = (hold >= 5);
            endcase
            fire       = w_valid_y_r && m_ready_y;
            prev_stall = w_valid_y_r && !m_ready_y;
            prev_r     = w_data_y_r;
            prev_l     = w_data_y_l;
            if (prev_stall) hold++;
            if (fire) begin
                chk($sformatf("y_relu[%0d]", idx), longint'($signed(w_data_y_r)), e1[idx]);
                chk($sformatf("y_lin[%0d]", idx),  longint'($signed(w_data_y_l)), e0[idx]);
                hold = 0;
                idx++;
                if (idx % P == 0) begin
                    t_prev = cyc;
                    seen   = 1'b0;
                end
            end
            tick();
        end
        s_valid_w = 1'b0;
        s_valid_x = 1'b0;
        m_ready_y = 1'b0;
        if (idx < M) chk("y_timeout", idx, M);
        chk("ready_x_after_last_y", w_ready_x_r, 1);
        chk("y_stable_under_stall", stab_bad, 0);
        chk("no_input_ready_in_output", rdy_bad, 0);
    endtask

    initial begin
        int e1 [M];
        int e0 [M];
        reset       = 1'b0;
        s_valid_w   = 1'b0;
        s_valid_x   = 1'b0;
        m_ready_y   = 1'b0;
        s_data_in_w = '0;
        s_data_in_x = '0;

        tbl[0].w = '{1, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 1};
        tbl[0].x = '{1, 2, 3};
        tbl[0].y1 = '{1, 2, 3, 6};
        tbl[0].y0 = '{1, 2, 3, 6};
        tbl[0].gap = 0;
        tbl[1].w = '{-1, -1, -1, 1, 0, 0, 0, -1, 0, 2, 2, 2};
        tbl[1].x = '{1, 2, 3};
        tbl[1].y1 = '{0, 1, 0, 12};
        tbl[1].y0 = '{-6, 1, -2, 12};
        tbl[1].gap = 30;
        tbl[2].w = '{default: 32767};
        tbl[2].x = '{default: 32767};
        tbl[2].y1 = '{default: 32767};
        tbl[2].y0 = '{default: 32767};
        tbl[2].gap = 20;
        tbl[3].w = '{default: -32768};
        tbl[3].x = '{default: 32767};
        tbl[3].y1 = '{default: 0};
        tbl[3].y0 = '{default: -32768};
        tbl[3].gap = 20;

        for (int e = 0; e < 4; e++) begin
            do_reset();
            for (int i = 0; i < M; i++)
                for (int j = 0; j < N; j++) wm[i][j] = tbl[e].w[i*N + j];
            for (int j = 0; j < N; j++) xv[j] = tbl[e].x[j];
            load_w(tbl[e].gap);
            load_x(tbl[e].gap);
            recv_y((e == 0) ? 0 : 1, tbl[e].y1, tbl[e].y0);
        end

        // Back-to-back vectors on one weight load, gappy x stream
        do_reset();
        set_basic_w();
        load_w(0);
        xv = '{1, 2, 3};
        load_x(40);
        e1 = '{1, 2, 3, 6};
        e0 = '{1, 2, 3, 6};
        recv_y(1, e1, e0);
        xv = '{-1, 4, 0};
        load_x(40);
        e1 = '{0, 4, 0, 3};
        e0 = '{-1, 4, 0, 3};
        recv_y(1, e1, e0);

        // Backpressure on every output element
        xv = '{1, 2, 3};
        load_x(0);
        e1 = '{1, 2, 3, 6};
        e0 = '{1, 2, 3, 6};
        recv_y(2, e1, e0);

        // One-cycle reset in the middle of COMPUTE, then reload and rerun
        load_x(0);
        tick();
        reset = 1'b0;
        #1;
        chk_idle("rst_mid");
        tick();
        reset = 1'b1;
        #1;
        chk("ready_w_after_mid_rst", w_ready_w_r, 1);
        chk("ready_x_after_mid_rst", w_ready_x_r, 0);
        chk("valid_y_after_mid_rst", w_valid_y_r, 0);
        load_w(0);
        load_x(0);
        recv_y(0, e1, e0);

        // Random weights and vectors against the reference model
        do_reset();
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) wm[i][j] = rnd_val();
        load_w(30);
        for (int v = 0; v < 6; v++) begin
            for (int j = 0; j < N; j++) xv[j] = rnd_val();
            for (int i = 0; i < M; i++) begin
                e1[i] = ref_y(i, 1'b1);
                e0[i] = ref_y(i, 1'b0);
            end
            load_x(30);
            recv_y(1, e1, e0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fc_layer_param.md
# fc_layer_param

Parametrised fully-connected layer for the multi-layer inference pipeline. It computes y = act(W·x) for an M×N signed weight matrix using P parallel multiply-accumulate lanes. Weights are loaded at run time over a dedicated stream, not fixed at synthesis. It drops into any stage of the layer chain using the same valid/ready stream protocol on input x and output y.

## Interface
- M, 8: output vector length (matrix rows); M % P == 0 required
- N, 8: input vector length (matrix columns)
- P, 2: parallel MAC lanes
- WIDTH, 16: signed data/weight width
- RELU, 1: 1 = clamp negative results to 0; 0 = pass signed result
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-low (reset asserted when 0)
- s_data_in_w  in  WIDTH  weight word, row-major order W[0][0..N-1], W[1][0..N-1], …
- s_valid_w  in  1  weight word valid
- s_ready_w  out  1  block accepts weight word
- s_data_in_x  in  WIDTH  input vector element, index 0 first
- s_valid_x  in  1  x element valid
- s_ready_x  out  1  block accepts x element
- m_data_out_y  out  WIDTH  output element, index 0 first
- m_valid_y  out  1  output element valid
- m_ready_y  in  1  downstream accepts output

## Operation
- A transfer occurs on any cycle where valid && ready are both high.
- State LOAD_W: s_ready_w=1.
  - Accept exactly M·N words into weight memory.
  - After the last word, go to LOAD_X.
  - Weights persist until the next reset; LOAD_W is never re-entered otherwise.
- State LOAD_X: s_ready_x=1.
  - Accept N elements into x memory.
  - After the last element, go to COMPUTE with group g=0.
- State COMPUTE: lanes k=0..P-1 accumulate row g·P+k over j=0..N-1.
  - One cycle issues the first memory read; then N MAC cycles follow.
  - Then go to OUTPUT.
- State OUTPUT: present lane results 0..P-1 in order, one per transfer.
  - After the P-th transfer: if g < M/P-1, increment g and return to COMPUTE.
  - Otherwise return to LOAD_X.
- Only one of s_ready_w, s_ready_x, m_valid_y is ever high at a time. No overlap between input and output phases.
- Arithmetic:
  - Each product is the full 2·WIDTH signed result.
  - The accumulator is 2·WIDTH+$clog2(N) bits signed and cleared at the start of each group.
  - Result = RELU ? max(acc,0) : acc.
  - The result is then saturated to [−2^(WIDTH−1), 2^(WIDTH−1)−1]. No wrap-around.
- Words presented on a stream whose ready is low are ignored and not counted.

## Timing
- During reset (reset=0): s_ready_w=0, s_ready_x=0, m_valid_y=0, m_data_out_y=0. All counters are cleared and the state is LOAD_W.
  - The first cycle after reset deasserts: s_ready_w=1.
- Reset mid-operation (any state): behaves exactly as above.
  - In-flight x data, partial sums and pending outputs are discarded.
  - Weights must be reloaded.
- s_ready_x rises on the cycle after the last weight transfer.
- Compute latency: m_valid_y first rises exactly N+2 cycles after the cycle of the last x transfer.
  - The same N+2 cycles apply after the last output transfer of a non-final group.
- While m_valid_y=1 and m_ready_y=0: m_data_out_y holds stable and m_valid_y stays high.
- Output elements within a group are back-to-back: with m_ready_y held high, one element transfers per cycle.
- After the final output transfer of the final group, s_ready_x=1 on the next cycle.
- Throughput per vector (no stalls): N + (M/P)·(N+1+P) cycles.

## Test plan
- Basic (M=4, N=3, P=2, RELU=1): W rows [1,0,0],[0,1,0],[0,0,1],[1,1,1]; x=[1,2,3] -> y=[1,2,3,6]. First y valid N+2=5 cycles after the last x transfer.
- Activation: row [−1,−1,−1] with x=[1,2,3] -> y=0 when RELU=1, y=−6 when RELU=0.
- Saturation (WIDTH=16, N=3): all weights and x = 32767 -> 32767. Weights −32768 with x=32767 and RELU=0 -> −32768.
- Backpressure: hold m_ready_y=0 for 5 cycles before each output.
  - Data stays stable and the value sequence is unchanged.
  - s_ready_x stays 0 until the last y transfer, then 1 next cycle.
- Back-to-back vectors: load weights once, stream x=[1,2,3] then x=[−1,4,0] with random s_valid_x gaps.
  - Expected y=[1,2,3,6] then [0,4,0,3] (RELU=1).
  - No weight reload is needed between vectors.
- Reset mid-COMPUTE: drive reset=0 for one cycle while in COMPUTE.
  - All outputs go to 0 and s_ready_w=1 the next cycle.
  - After reloading weights, the basic test reproduces y=[1,2,3,6].
